acc_collector_pipe: RTL and testbench
=====================================

Name: acc_collector_pipe

Overview:
- Parametrised successor to the partial-sum collector.
- Holds a DEPTH-entry buffer of LANES signed partial sums per entry. It accumulates MAC-array results internally across multiple K-passes.
- It then streams the finished tile to the PPU through a valid/ready interface with backpressure.
- Sits between the mac_16-class array and the PPU.

Parameters:
- LANES, 16: partial-sum lanes per entry (one per MAC unit).
- PSUM_W, 24: bits per lane, signed two's complement.
- DEPTH, 16: buffer entries (rows per tile); power of two, at least 2.
- PASS_W, 8: width of the pass counter.
- Derived localparam AW = $clog2(DEPTH).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin tile; sampled only in IDLE.
- num_rows  in  AW+1  active entries for the tile, sampled at start. 0 or values greater than DEPTH mean DEPTH.
- ps_valid  in  1  MAC result beat valid.
- ps_ready  out  1  collector accepts a beat.
- ps_data  in  LANES*PSUM_W  MAC result; lane i is at [i*PSUM_W +: PSUM_W].
- flush  in  1  request drain at the next pass boundary.
- out_valid  out  1  drain beat valid.
- out_ready  in  1  PPU accepts a beat.
- out_data  out  LANES*PSUM_W  drained entry.
- out_last  out  1  final drain beat.
- done  out  1  one-cycle pulse when the tile has fully drained.
- busy  out  1  high whenever state is not IDLE.
- pass_count  out  PASS_W  completed passes in the current tile.
- sat_flag  out  1  sticky saturation indicator (see Optional Feature).

Behaviour:
- Reset, synchronous: state IDLE; all entries zero; pointers zero; flush_pend zero. All outputs are 0: ps_ready, out_valid, out_data, out_last, done, busy, pass_count, sat_flag.
- States are IDLE, ACCUM and DRAIN.
- IDLE:
  - ps_ready=0, out_valid=0.
  - On start: latch rows_q from num_rows, zero every entry, set wr_ptr=0, pass_count=0, sat_flag=0, flush_pend=0. Next state is ACCUM.
- ACCUM:
  - ps_ready=1.
  - On ps_valid&&ps_ready, every lane updates entry[wr_ptr] <= entry[wr_ptr] + ps_data. Result is registered with 1-cycle latency.
  - If wr_ptr==rows_q-1: wr_ptr wraps to 0 and pass_count increments, saturating at 2^PASS_W-1. Otherwise wr_ptr increments.
  - flush is latched into flush_pend.
  - At a pass boundary (wr_ptr==0 after the update), if flush_pend or flush is set, go to DRAIN next cycle; ps_ready drops in that cycle.
  - Final beat of a pass together with flush in the same cycle: the beat is accumulated, then DRAIN.
  - flush when pass_count==0 and wr_ptr==0 drains the zeroed buffer.
- DRAIN:
  - ps_ready=0, out_valid=1, out_data=entry[rd_ptr], out_last=(rd_ptr==rows_q-1).
  - Data is held stable while out_valid&&!out_ready.
  - Each handshake advances rd_ptr.
  - After the last handshake: next cycle state is IDLE and done=1 for exactly one cycle. rd_ptr is 0 and entries are retained.
- out_data and out_last are zero outside DRAIN.
- start is ignored outside IDLE. start in the same cycle as a done pulse is honoured only from IDLE, i.e. the following cycle.
- Arithmetic is signed per lane with no cross-lane carry. By default it wraps modulo 2^PSUM_W.
- rst asserted in any state overrides all other inputs and returns to the reset state next cycle.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined:
  - Lane sums clamp to the signed limits 2^(PSUM_W-1)-1 and -2^(PSUM_W-1).
  - Any clamp sets sat_flag, which is sticky until the next start or rst.
- Undefined:
  - Sums wrap.
  - sat_flag is tied to 0.

Test Plan:
1. Basic tile: num_rows=4, three passes with ps_data lane i = i+1 on every beat, then flush. Drain returns 4 beats, each lane i = 3*(i+1). out_last is set on beat 4 only; done pulses once; pass_count=3.
2. Backpressure: in DRAIN, out_ready pattern 1,0,1,0,... gives exactly 4 beats, in order, with no duplicates. out_data is stable during stalls.
3. Deferred flush: num_rows=4, flush pulsed after 2 beats of pass 2. State stays ACCUM (ps_ready=1) until 2 more beats are accepted, then DRAIN. Each entry holds the sum of both passes.
4. Overflow: lane0 holds 24'h7FFFF0 and receives +24'h000020.
   - Macro undefined: drains 24'h800010, sat_flag=0.
   - ACC_SATURATE_EN defined: drains 24'h7FFFFF, sat_flag=1.
5. Reset mid-DRAIN: rst high for 1 cycle during beat 2. Next cycle all outputs are 0 and state is IDLE; a subsequent flush-only tile drains zeros. A start issued during ACCUM has no effect.
6. num_rows=0: behaves as 16 rows; drain emits 16 beats, with out_last on beat 16.

Source files
------------

// File: rtl/acc_collector_pipe.sv
// ----------------------------------------------------------------------------
// acc_collector_pipe
//
// Partial-sum collector between the MAC array and the PPU. Holds DEPTH
// entries of LANES signed PSUM_W-bit sums, accumulates MAC result beats into
// them over several K-passes, then streams the finished tile out through a
// valid/ready interface that honours backpressure.
//
// Optional feature: define ACC_SATURATE_EN to clamp every lane sum to the
// signed PSUM_W range and raise the sticky sat_flag. Without it, sums wrap
// and sat_flag is tied to 0.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         begin a tile (IDLE only); num_rows latched with it
//   num_rows      active entries; 0 or > DEPTH selects DEPTH
//   ps_valid/ps_ready/ps_data   MAC result beats, one entry per beat
//   flush         drain at the next pass boundary
//   out_valid/out_ready/out_data/out_last   drain stream to the PPU
//   done          one-cycle pulse after the final drain handshake
//   busy          high whenever not IDLE
//   pass_count    completed passes in the current tile (saturating)
//   sat_flag      sticky clamp indicator
// ----------------------------------------------------------------------------
module acc_collector_pipe #(
    parameter int  LANES  = 16,
    parameter int  PSUM_W = 24,
    parameter int  DEPTH  = 16,
    parameter int  PASS_W = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [AW:0]               num_rows,
    input  logic                      ps_valid,
    output logic                      ps_ready,
    input  logic [LANES*PSUM_W-1:0]   ps_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*PSUM_W-1:0]   out_data,
    output logic                      out_last,
    output logic                      done,
    output logic                      busy,
    output logic [PASS_W-1:0]         pass_count,
    output logic                      sat_flag
);

    localparam int                DW       = LANES * PSUM_W;
    localparam logic [AW:0]       DEPTH_N  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]       ONE_N    = (AW + 1)'(1);
    localparam logic [PASS_W-1:0] PASS_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     entry_q [DEPTH];
    logic [AW:0]       rows_q;
    logic [AW:0]       rows_eff;
    logic [AW:0]       last_idx;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q;
    logic [PASS_W-1:0] pass_q;
    logic              flush_pend_q;
    logic              done_q;
    logic              accept;
    logic              wr_is_last;
    logic              rd_is_last;
    logic [DW-1:0]     sum_vec;

    assign rows_eff   = (num_rows == '0 || num_rows > DEPTH_N) ? DEPTH_N : num_rows;
    assign last_idx   = rows_q - ONE_N;
    assign wr_is_last = ({1'b0, wr_ptr_q} == last_idx);
    assign rd_is_last = ({1'b0, rd_ptr_q} == last_idx);
    assign accept     = (state_q == S_ACCUM) && ps_valid;

    // Write pointer after this cycle; a value of 0 marks a pass boundary.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (accept) begin
            wr_ptr_d = wr_is_last ? '0 : wr_ptr_q + AW'(1);
        end
    end

    // Per-lane adder: no carry crosses a lane boundary.
`ifdef ACC_SATURATE_EN
    logic              sat_q;
    logic              sat_hit;
    logic [PSUM_W:0]   lane_wide;

    always_comb begin
        sum_vec   = '0;
        sat_hit   = 1'b0;
        lane_wide = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_wide = {entry_q[wr_ptr_q][i*PSUM_W + PSUM_W-1], entry_q[wr_ptr_q][i*PSUM_W +: PSUM_W]}
                      + {ps_data[i*PSUM_W + PSUM_W-1], ps_data[i*PSUM_W +: PSUM_W]};
            // The two top bits disagree exactly when the signed sum overflowed.
            if (lane_wide[PSUM_W] != lane_wide[PSUM_W-1]) begin
                sat_hit = 1'b1;
                sum_vec[i*PSUM_W +: PSUM_W] = lane_wide[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}}
                                                                : {1'b0, {(PSUM_W-1){1'b1}}};
            end else begin
                sum_vec[i*PSUM_W +: PSUM_W] = lane_wide[PSUM_W-1:0];
            end
        end
    end

    assign sat_flag = sat_q;
`else
    always_comb begin
        sum_vec = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_vec[i*PSUM_W +: PSUM_W] = entry_q[wr_ptr_q][i*PSUM_W +: PSUM_W]
                                        + ps_data[i*PSUM_W +: PSUM_W];
        end
    end

    assign sat_flag = 1'b0;
`endif

    // FSM state register.
    // NOTE: sequential blocks use <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and handshake outputs.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        state_d   = state_q;
        ps_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                ps_ready = 1'b1;
                if (wr_ptr_d == '0 && (flush_pend_q || flush)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_data  = entry_q[rd_ptr_q];
                out_last  = rd_is_last;
                if (out_ready && rd_is_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers and the entry buffer.
    // NOTE: entries are flops, not RAM, so clearing all of them on reset
    // and on start is legal; a RAM macro would need a clear sweep instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                entry_q[r] <= '0;
            end
            rows_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pass_q       <= '0;
            flush_pend_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef ACC_SATURATE_EN
            sat_q        <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        for (int r = 0; r < DEPTH; r++) begin
                            entry_q[r] <= '0;
                        end
                        rows_q       <= rows_eff;
                        wr_ptr_q     <= '0;
                        pass_q       <= '0;
                        flush_pend_q <= 1'b0;
`ifdef ACC_SATURATE_EN
                        sat_q        <= 1'b0;
`endif
                    end
                end
                S_ACCUM: begin
                    flush_pend_q <= flush_pend_q | flush;
                    if (accept) begin
                        entry_q[wr_ptr_q] <= sum_vec;
                        wr_ptr_q          <= wr_ptr_d;
                        if (wr_is_last && pass_q != PASS_MAX) begin
                            pass_q <= pass_q + PASS_W'(1);
                        end
`ifdef ACC_SATURATE_EN
                        sat_q <= sat_q | sat_hit;
`endif
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (rd_is_last) begin
                            rd_ptr_q <= '0;
                            done_q   <= 1'b1;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign done       = done_q;
    assign busy       = (state_q != S_IDLE);
    assign pass_count = pass_q;

endmodule

// File: tb/tb_acc_collector_pipe.sv
// ----------------------------------------------------------------------------
// tb_acc_collector_pipe
//
// Directed bench for acc_collector_pipe at default parameters: basic tile,
// drain backpressure, deferred flush, lane overflow (wrap or clamp depending
// on ACC_SATURATE_EN), reset in the middle of a drain, and num_rows values
// that select the full depth.
// ----------------------------------------------------------------------------
module tb_acc_collector_pipe;

    localparam int LANES  = 16;
    localparam int PSUM_W = 24;
    localparam int DEPTH  = 16;
    localparam int PASS_W = 8;
    localparam int AW     = 4;
    localparam int DW     = LANES * PSUM_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic [AW:0]       num_rows;
    logic              ps_valid;
    logic              ps_ready;
    logic [DW-1:0]     ps_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic              done;
    logic              busy;
    logic [PASS_W-1:0] pass_count;
    logic              sat_flag;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    logic [DW-1:0] exp_beat [DEPTH];

    acc_collector_pipe #(
        .LANES  (LANES),
        .PSUM_W (PSUM_W),
        .DEPTH  (DEPTH),
        .PASS_W (PASS_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_rows   (num_rows),
        .ps_valid   (ps_valid),
        .ps_ready   (ps_ready),
        .ps_data    (ps_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .done       (done),
        .busy       (busy),
        .pass_count (pass_count),
        .sat_flag   (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] lane_vec(input int k);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) begin
            v[i*PSUM_W +: PSUM_W] = PSUM_W'(k * (i + 1));
        end
        return v;
    endfunction

    task automatic start_tile(input logic [AW:0] n);
        start    = 1'b1;
        num_rows = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic fl);
        ps_valid = 1'b1;
        ps_data  = d;
        flush    = fl;
        tick();
        ps_valid = 1'b0;
        ps_data  = '0;
        flush    = 1'b0;
    endtask

    task automatic flush_only();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Drain n beats against exp_beat[]; bp selects out_ready = 1,0,1,0,...
    task automatic drain(input string tag, input int n, input bit bp);
        int t;
        int beats;
        int guard;
        t = 0;
        while (!out_valid && t < 20) begin
            tick();
            t++;
        end
        check({tag, "_enter"}, DW'(out_valid), DW'(1));
        check({tag, "_ps_ready"}, DW'(ps_ready), DW'(0));
        beats = 0;
        guard = 0;
        while (beats < n && guard < 200) begin
            out_ready = bp ? ((guard % 2) == 0) : 1'b1;
            check($sformatf("%s_valid%0d", tag, beats), DW'(out_valid), DW'(1));
            check($sformatf("%s_data%0d", tag, beats), out_data, exp_beat[beats]);
            check($sformatf("%s_last%0d", tag, beats), DW'(out_last), DW'(beats == n - 1));
            tick();
            if (out_ready) beats++;
            guard++;
        end
        out_ready = 1'b0;
        check({tag, "_beats"}, DW'(beats), DW'(n));
        check({tag, "_done"}, DW'(done), DW'(1));
        check({tag, "_idle_valid"}, DW'(out_valid), DW'(0));
        check({tag, "_idle_data"}, out_data, '0);
        check({tag, "_idle_busy"}, DW'(busy), DW'(0));
        tick();
        check({tag, "_done_once"}, DW'(done), DW'(0));
    endtask

    initial begin
        logic [DW-1:0] v;

        rst       = 1'b1;
        start     = 1'b0;
        num_rows  = '0;
        ps_valid  = 1'b0;
        ps_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check("rst_ps_ready", DW'(ps_ready), DW'(0));
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_out_data", out_data, '0);
        check("rst_out_last", DW'(out_last), DW'(0));
        check("rst_done", DW'(done), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_pass", DW'(pass_count), DW'(0));
        check("rst_sat", DW'(sat_flag), DW'(0));

        // 1: three passes of lane i = i+1 over 4 rows, then flush.
        start_tile(5'd4);
        check("t1_busy", DW'(busy), DW'(1));
        check("t1_ps_ready", DW'(ps_ready), DW'(1));
        for (int b = 0; b < 12; b++) send_beat(lane_vec(1), 1'b0);
        check("t1_pass", DW'(pass_count), DW'(3));
        flush_only();
        for (int r = 0; r < DEPTH; r++) exp_beat[r] = lane_vec(3);
        drain("t1", 4, 1'b0);
        check("t1_pass_after", DW'(pass_count), DW'(3));

        // 2: one pass with per-row data, flush with the final beat,
        //    drained under 1,0,1,0 backpressure.
        start_tile(5'd4);
        for (int r = 0; r < 4; r++) send_beat(lane_vec(r + 1), r == 3);
        for (int r = 0; r < 4; r++) exp_beat[r] = lane_vec(r + 1);
        drain("t2", 4, 1'b1);

        // 3: deferred flush after 2 beats of pass 2.
        start_tile(5'd4);
        for (int r = 0; r < 4; r++) send_beat(lane_vec(r + 1), 1'b0);
        for (int r = 0; r < 2; r++) send_beat(lane_vec(2 * (r + 1)), 1'b0);
        flush_only();
        check("t3_hold_ready", DW'(ps_ready), DW'(1));
        check("t3_hold_valid", DW'(out_valid), DW'(0));
        send_beat(lane_vec(6), 1'b0);
        check("t3_still_accum", DW'(ps_ready), DW'(1));
        send_beat(lane_vec(8), 1'b0);
        check("t3_pass", DW'(pass_count), DW'(2));
        for (int r = 0; r < 4; r++) exp_beat[r] = lane_vec(3 * (r + 1));
        drain("t3", 4, 1'b0);

        // 4: overflow on lane 0 (positive) and lane 1 (negative), one row.
        start_tile(5'd1);
        v = '0;
        v[23:0]  = 24'h7FFFF0;
        v[47:24] = 24'h800000;
        send_beat(v, 1'b0);
        v = '0;
        v[23:0]  = 24'h000020;
        v[47:24] = 24'hFFFFFF;
        send_beat(v, 1'b0);
        v = '0;
`ifdef ACC_SATURATE_EN
        v[23:0]  = 24'h7FFFFF;
        v[47:24] = 24'h800000;
        check("t4_sat", DW'(sat_flag), DW'(1));
`else
        v[23:0]  = 24'h800010;
        v[47:24] = 24'h7FFFFF;
        check("t4_sat", DW'(sat_flag), DW'(0));
`endif
        check("t4_pass", DW'(pass_count), DW'(2));
        flush_only();
        exp_beat[0] = v;
        drain("t4", 1, 1'b0);
        start_tile(5'd4);
        check("t4_sat_cleared", DW'(sat_flag), DW'(0));

        // 5: reset during drain beat 2, then a flush-only tile.
        for (int b = 0; b < 4; b++) send_beat(lane_vec(1), 1'b0);
        flush_only();
        out_ready = 1'b1;
        check("t5_beat1", out_data, lane_vec(1));
        tick();
        check("t5_beat2_valid", DW'(out_valid), DW'(1));
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_ps_ready", DW'(ps_ready), DW'(0));
        check("t5_out_valid", DW'(out_valid), DW'(0));
        check("t5_out_data", out_data, '0);
        check("t5_out_last", DW'(out_last), DW'(0));
        check("t5_done", DW'(done), DW'(0));
        check("t5_busy", DW'(busy), DW'(0));
        check("t5_pass", DW'(pass_count), DW'(0));
        check("t5_sat", DW'(sat_flag), DW'(0));
        start_tile(5'd4);
        start_tile(5'd2);
        check("t5_start_ignored", DW'(ps_ready), DW'(1));
        flush_only();
        for (int r = 0; r < DEPTH; r++) exp_beat[r] = '0;
        drain("t5", 4, 1'b0);

        // 6: num_rows=0 selects all 16 rows.
        start_tile(5'd0);
        for (int r = 0; r < 16; r++) send_beat(lane_vec(r + 1), r == 15);
        check("t6_pass", DW'(pass_count), DW'(1));
        for (int r = 0; r < 16; r++) exp_beat[r] = lane_vec(r + 1);
        drain("t6", 16, 1'b0);

        // num_rows above DEPTH also selects 16; flush-only at pass 0.
        start_tile(5'd20);
        flush_only();
        check("t7_pass", DW'(pass_count), DW'(0));
        for (int r = 0; r < DEPTH; r++) exp_beat[r] = '0;
        drain("t7", 16, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
